// File: rtl/rsp_merge_pkg.sv
// Shared widths, tuser field offsets, FSM encodings and helpers for rsp_merge.
// Optional feature macro: RSP_MERGE_LEN_CHK_EN (merged-length compare in rsp_merge_chk).
`ifndef DMA_DATA_W
`define DMA_DATA_W 256
`endif
`ifndef DMA_KEEP_W
`define DMA_KEEP_W 8
`endif
`ifndef AXIS_TUSER_W
`define AXIS_TUSER_W 108
`endif

package rsp_merge_pkg;

  localparam int unsigned DataW  = `DMA_DATA_W;
  localparam int unsigned KeepW  = `DMA_KEEP_W;
  localparam int unsigned TuserW = `AXIS_TUSER_W;
  localparam int unsigned LenW   = 11;
  localparam int unsigned TagW   = 8;

  localparam int unsigned UReqTypeLsb = 104;
  localparam int unsigned UTagLsb     = 96;
  localparam int unsigned UAddrLsb    = 32;
  localparam int unsigned UTotLsb     = 20;
  localparam int unsigned UFinalBit   = 19;
  localparam int unsigned USubLsb     = 8;

  localparam logic [3:0] StIdle   = 4'b0001;
  localparam logic [3:0] StFirst  = 4'b0010;
  localparam logic [3:0] StMid    = 4'b0100;
  localparam logic [3:0] StSubEnd = 4'b1000;

  function automatic logic [LenW-1:0] popcount(input logic [KeepW-1:0] keep);
    logic [LenW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < KeepW; i++) begin
      n = n + LenW'(keep[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rsp_merge_chk.sv
// Merge checker: DW counter, tag / sub-length / total-length checks, saturating error count.
// Macro RSP_MERGE_LEN_CHK_EN enables the total-length compare at the merged last beat.
module rsp_merge_chk
  import rsp_merge_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_acc,
  input  logic            i_first,
  input  logic            i_run_start,
  input  logic [KeepW-1:0] i_keep,
  input  logic [TagW-1:0] i_tag,
  input  logic [TagW-1:0] i_run_tag,
  input  logic            i_final,
  input  logic [LenW-1:0] i_sub_len,
  input  logic            i_out_last,
  input  logic [LenW-1:0] i_total,
  output logic            o_err,
  output logic [15:0]     o_err_cnt
);

  logic [LenW-1:0] r_dw_cnt;
  logic [LenW-1:0] w_cnt_d;
  logic            w_tag_err;
  logic            w_len_err;
  logic            w_total_err;
  logic            w_err;

  assign w_tag_err = i_acc & i_first & ~i_run_start & (i_tag != i_run_tag);
  assign w_len_err = i_acc & i_first & ~i_final & ((i_sub_len % LenW'(KeepW)) != '0);

`ifdef RSP_MERGE_LEN_CHK_EN
  assign w_total_err = i_out_last & (r_dw_cnt != i_total);
`else
  logic w_unused_total;
  assign w_unused_total = ^i_total;
  assign w_total_err    = 1'b0;
`endif

  assign w_err = w_tag_err | w_len_err | w_total_err;

  // Clear and add can coincide when a new run starts as the previous one leaves.
  always_comb begin
    w_cnt_d = r_dw_cnt;
    if (i_out_last) w_cnt_d = '0;
    if (i_acc) w_cnt_d = w_cnt_d + popcount(i_keep);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dw_cnt  <= '0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      r_dw_cnt <= w_cnt_d;
      o_err    <= w_err;
      if (w_err && (o_err_cnt != 16'hFFFF)) o_err_cnt <= o_err_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/rsp_merge.sv
// rsp_merge: concatenates an in-order run of sub-responses into one AXI-S packet.
// Macro RSP_MERGE_LEN_CHK_EN enables the merged-length check inside rsp_merge_chk.
module rsp_merge
  import rsp_merge_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sub_valid,
  input  logic              i_sub_last,
  output logic              o_sub_ready,
  input  logic [DataW-1:0]  i_sub_data,
  input  logic [KeepW-1:0]  i_sub_keep,
  input  logic [TuserW-1:0] i_sub_user,
  output logic              o_m_valid,
  output logic              o_m_last,
  input  logic              i_m_ready,
  output logic [DataW-1:0]  o_m_data,
  output logic [KeepW-1:0]  o_m_keep,
  output logic [TuserW-1:0] o_m_user,
  output logic              o_err,
  output logic [15:0]       o_err_cnt
);

  logic              r_vld;
  logic              r_last;
  logic              r_final;
  logic [DataW-1:0]  r_data;
  logic [KeepW-1:0]  r_keep;
  logic [TuserW-1:0] r_muser;
  logic [TagW-1:0]   r_tag;
  logic [LenW-1:0]   r_total;
  logic [3:0]        r_state;
  logic [3:0]        w_state_d;
  logic              w_acc;
  logic              w_out_last;
  logic              w_first_in;
  logic              w_run_start;
  logic [TuserW-1:0] w_muser_first;

  assign o_sub_ready = ~r_vld | i_m_ready;
  assign w_acc       = i_sub_valid & o_sub_ready;
  assign o_m_valid   = r_vld;
  assign o_m_last    = r_vld & r_last & r_final;
  assign o_m_data    = r_data;
  assign o_m_keep    = r_keep;
  assign o_m_user    = r_muser;
  assign w_out_last  = o_m_last & i_m_ready;

  // Next accepted beat opens a sub-response after a sub_last; it opens a run if that was final.
  assign w_first_in  = (r_state == StIdle) | (r_state == StSubEnd);
  assign w_run_start = (r_state == StIdle) | ((r_state == StSubEnd) & r_final);

  always_comb begin
    w_muser_first                    = i_sub_user;
    w_muser_first[USubLsb +: LenW]   = i_sub_user[UTotLsb +: LenW];
    w_muser_first[UFinalBit]         = 1'b1;
  end

  always_comb begin
    w_state_d = r_state;
    if (w_acc) begin
      if (i_sub_last)      w_state_d = StSubEnd;
      else if (w_first_in) w_state_d = StFirst;
      else                 w_state_d = StMid;
    end else if (w_out_last) begin
      w_state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
      r_final <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_muser <= '0;
      r_tag   <= '0;
      r_total <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_acc) begin
        r_vld  <= 1'b1;
        r_data <= i_sub_data;
        r_keep <= i_sub_keep;
        r_last <= i_sub_last;
      end else if (i_m_ready) begin
        r_vld <= 1'b0;
      end
      if (w_acc && w_first_in) begin
        r_tag   <= i_sub_user[UTagLsb +: TagW];
        r_total <= i_sub_user[UTotLsb +: LenW];
        r_final <= i_sub_user[UFinalBit];
      end
      if (w_acc && w_run_start) r_muser <= w_muser_first;
      else if (w_out_last)      r_muser <= '0;
    end
  end

  rsp_merge_chk u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_acc       (w_acc),
    .i_first     (w_first_in),
    .i_run_start (w_run_start),
    .i_keep      (i_sub_keep),
    .i_tag       (i_sub_user[UTagLsb +: TagW]),
    .i_run_tag   (r_tag),
    .i_final     (i_sub_user[UFinalBit]),
    .i_sub_len   (i_sub_user[USubLsb +: LenW]),
    .i_out_last  (w_out_last),
    .i_total     (r_total),
    .o_err       (o_err),
    .o_err_cnt   (o_err_cnt)
  );

endmodule

// File: tb/tb_rsp_merge.sv
// Directed bench for rsp_merge: merges, length/tag errors, backpressure, reset mid-packet.
module tb_rsp_merge;
  import rsp_merge_pkg::*;

`ifdef RSP_MERGE_LEN_CHK_EN
  localparam int LenChk = 1;
`else
  localparam int LenChk = 0;
`endif

  typedef struct packed {
    logic [DataW-1:0]  data;
    logic [KeepW-1:0]  keep;
    logic              last;
    logic [TuserW-1:0] user;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_sub_valid, i_sub_last, o_sub_ready;
  logic [DataW-1:0]  i_sub_data;
  logic [KeepW-1:0]  i_sub_keep;
  logic [TuserW-1:0] i_sub_user;
  logic              o_m_valid, o_m_last, i_m_ready;
  logic [DataW-1:0]  o_m_data;
  logic [KeepW-1:0]  o_m_keep;
  logic [TuserW-1:0] o_m_user;
  logic              o_err;
  logic [15:0]       o_err_cnt;

  initial forever #5 clk = ~clk;

  rsp_merge dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sub_valid (i_sub_valid),
    .i_sub_last  (i_sub_last),
    .o_sub_ready (o_sub_ready),
    .i_sub_data  (i_sub_data),
    .i_sub_keep  (i_sub_keep),
    .i_sub_user  (i_sub_user),
    .o_m_valid   (o_m_valid),
    .o_m_last    (o_m_last),
    .i_m_ready   (i_m_ready),
    .o_m_data    (o_m_data),
    .o_m_keep    (o_m_keep),
    .o_m_user    (o_m_user),
    .o_err       (o_err),
    .o_err_cnt   (o_err_cnt)
  );

  beat_t             in_q[$], exp_q[$], got_q[$];
  logic [TuserW-1:0] exp_user_q[$];
  logic [LenW-1:0]   exp_dw_q[$], dw_q[$];
  int n_checks = 0, n_errors = 0;
  int n_errp, n_gaps, exp_err_cnt = 0, seq = 0;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TuserW-1:0] mk_user(input logic [7:0] tag, input logic [63:0] addr,
                                                input logic [10:0] tot, input logic fin,
                                                input logic [10:0] sub);
    logic [TuserW-1:0] u;
    u = '0;
    u[107:104] = 4'h2;
    u[103:96]  = tag;
    u[95:32]   = addr;
    u[30:20]   = tot;
    u[19]      = fin;
    u[18:8]    = sub;
    return u;
  endfunction

  task automatic clear_all();
    in_q.delete(); exp_q.delete(); exp_user_q.delete(); exp_dw_q.delete();
  endtask

  // One sub-response of nbeats; only the last beat carries last_keep.
  task automatic add_sub(input logic [7:0] tag, input logic [63:0] addr, input logic [10:0] tot,
                         input logic fin, input logic [10:0] sub, input int nbeats,
                         input logic [KeepW-1:0] last_keep);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      seq++;
      b.data = {8{32'hA500_0000 | 32'(seq)}};
      b.keep = (i == nbeats - 1) ? last_keep : {KeepW{1'b1}};
      b.last = (i == nbeats - 1);
      b.user = mk_user(tag, addr, tot, fin, sub);
      in_q.push_back(b);
      b.last = b.last & fin;
      b.user = '0;
      exp_q.push_back(b);
    end
  endtask

  task automatic run_traffic(input int rdy_mode, input int stop_out);
    int idx = 0, cyc = 0, tail = 0;
    logic hold_v = 1'b0;
    logic [511:0] held = '0;
    logic done = 1'b0;
    got_q.delete(); dw_q.delete(); n_errp = 0; n_gaps = 0;
    while (cyc < 400 && !done) begin
      @(posedge clk); #1;
      i_sub_valid = (idx < in_q.size());
      if (idx < in_q.size()) begin
        i_sub_data = in_q[idx].data;
        i_sub_keep = in_q[idx].keep;
        i_sub_last = in_q[idx].last;
        i_sub_user = in_q[idx].user;
      end
      i_m_ready = (rdy_mode == 0) || (cyc % 2 == 0);
      @(negedge clk);
      if (o_err) n_errp++;
      if (hold_v) begin
        check_eq("stall_hold", 512'({o_m_data, o_m_keep, o_m_last, o_m_user}), held);
        hold_v = 1'b0;
      end
      if (o_m_valid && !i_m_ready) begin
        hold_v = 1'b1;
        held   = 512'({o_m_data, o_m_keep, o_m_last, o_m_user});
      end
      if (i_sub_valid && o_sub_ready) idx++;
      if (o_m_valid && i_m_ready) begin
        got_q.push_back({o_m_data, o_m_keep, o_m_last, o_m_user});
        if (o_m_last) dw_q.push_back(dut.u_chk.r_dw_cnt);
      end else if (i_m_ready && got_q.size() > 0 && got_q.size() < exp_q.size()) begin
        n_gaps++;
      end
      if (stop_out > 0 && got_q.size() == stop_out) done = 1'b1;
      if (got_q.size() >= exp_q.size() && idx == in_q.size()) begin
        tail++;
        if (tail > 3) done = 1'b1;
      end
      cyc++;
    end
    check_eq("timeout", 512'(done), 512'(1));
    i_sub_valid = 1'b0;
    i_m_ready   = 1'b1;
  endtask

  task automatic check_results(input string name, input int exp_errp);
    int pkt = 0;
    exp_err_cnt += exp_errp;
    check_eq({name, ".beats"}, 512'(got_q.size()), 512'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check_eq($sformatf("%s.beat%0d", name, i),
               512'({got_q[i].data, got_q[i].keep, got_q[i].last}),
               512'({exp_q[i].data, exp_q[i].keep, exp_q[i].last}));
      if (pkt < exp_user_q.size())
        check_eq($sformatf("%s.user%0d", name, i), 512'(got_q[i].user), 512'(exp_user_q[pkt]));
      if (exp_q[i].last) pkt++;
    end
    check_eq({name, ".dw_n"}, 512'(dw_q.size()), 512'(exp_dw_q.size()));
    for (int i = 0; i < dw_q.size() && i < exp_dw_q.size(); i++)
      check_eq($sformatf("%s.dw%0d", name, i), 512'(dw_q[i]), 512'(exp_dw_q[i]));
    check_eq({name, ".err_pulses"}, 512'(n_errp), 512'(exp_errp));
    check_eq({name, ".err_cnt"}, 512'(o_err_cnt), 512'(exp_err_cnt));
    check_eq({name, ".gaps"}, 512'(n_gaps), 512'(0));
    check_eq({name, ".user_idle"}, 512'(o_m_user), 512'(0));
  endtask

  initial begin
    i_sub_valid = 1'b0; i_sub_last = 1'b0; i_sub_data = '0; i_sub_keep = '0;
    i_sub_user = '0; i_m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.m_valid", 512'(o_m_valid), 512'(0));
    check_eq("rst.m_last", 512'(o_m_last), 512'(0));
    check_eq("rst.m_user", 512'(o_m_user), 512'(0));
    check_eq("rst.m_data", 512'(o_m_data), 512'(0));
    check_eq("rst.m_keep", 512'(o_m_keep), 512'(0));
    check_eq("rst.err", 512'(o_err), 512'(0));
    check_eq("rst.err_cnt", 512'(o_err_cnt), 512'(0));
    check_eq("rst.sub_ready", 512'(o_sub_ready), 512'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // 64 DW as 32 + 32
    clear_all();
    add_sub(8'h11, 64'h1000, 11'd64, 1'b0, 11'd32, 4, 8'hFF);
    add_sub(8'h11, 64'h1080, 11'd64, 1'b1, 11'd32, 4, 8'hFF);
    exp_user_q.push_back(mk_user(8'h11, 64'h1000, 11'd64, 1'b1, 11'd64));
    exp_dw_q.push_back(11'd64);
    run_traffic(0, 0);
    check_results("m64", 0);

    // 37 DW as 32 + 5
    clear_all();
    add_sub(8'h21, 64'h3000, 11'd37, 1'b0, 11'd32, 4, 8'hFF);
    add_sub(8'h21, 64'h3080, 11'd37, 1'b1, 11'd5, 1, 8'h1F);
    exp_user_q.push_back(mk_user(8'h21, 64'h3000, 11'd37, 1'b1, 11'd37));
    exp_dw_q.push_back(11'd37);
    run_traffic(0, 0);
    check_results("m37", 0);

    // tag change mid-run
    clear_all();
    add_sub(8'h11, 64'h4000, 11'd64, 1'b0, 11'd32, 4, 8'hFF);
    add_sub(8'h12, 64'h4080, 11'd64, 1'b1, 11'd32, 4, 8'hFF);
    exp_user_q.push_back(mk_user(8'h11, 64'h4000, 11'd64, 1'b1, 11'd64));
    exp_dw_q.push_back(11'd64);
    run_traffic(0, 0);
    check_results("tag", 1);

    // total says 64, only 56 delivered
    clear_all();
    add_sub(8'h31, 64'h5000, 11'd64, 1'b0, 11'd32, 4, 8'hFF);
    add_sub(8'h31, 64'h5080, 11'd64, 1'b1, 11'd24, 3, 8'hFF);
    exp_user_q.push_back(mk_user(8'h31, 64'h5000, 11'd64, 1'b1, 11'd64));
    exp_dw_q.push_back(11'd56);
    run_traffic(0, 0);
    check_results("short", LenChk);

    // non-final sub of 28 DW (not a multiple of 8)
    clear_all();
    add_sub(8'h41, 64'h6000, 11'd36, 1'b0, 11'd28, 4, 8'h0F);
    add_sub(8'h41, 64'h6070, 11'd36, 1'b1, 11'd8, 1, 8'hFF);
    exp_user_q.push_back(mk_user(8'h41, 64'h6000, 11'd36, 1'b1, 11'd36));
    exp_dw_q.push_back(11'd36);
    run_traffic(0, 0);
    check_results("sublen", 1);

    // three 1-beat requests, m_ready toggling, then back-to-back at full rate
    for (int mode = 1; mode >= 0; mode--) begin
      clear_all();
      for (int k = 0; k < 3; k++) begin
        add_sub(8'(8'h50 + k), 64'h7000 + 64'(k * 32), 11'd8, 1'b1, 11'd8, 1, 8'hFF);
        exp_user_q.push_back(mk_user(8'(8'h50 + k), 64'h7000 + 64'(k * 32), 11'd8, 1'b1, 11'd8));
        exp_dw_q.push_back(11'd8);
      end
      run_traffic(mode, 0);
      check_results(mode == 1 ? "b2b_tog" : "b2b_full", 0);
    end

    // reset after three output beats of a 64-DW merge
    clear_all();
    add_sub(8'h61, 64'h8000, 11'd64, 1'b0, 11'd32, 4, 8'hFF);
    add_sub(8'h61, 64'h8080, 11'd64, 1'b1, 11'd32, 4, 8'hFF);
    run_traffic(0, 3);
    rst_n = 1'b0;
    #1;
    check_eq("mrst.m_valid", 512'(o_m_valid), 512'(0));
    check_eq("mrst.m_last", 512'(o_m_last), 512'(0));
    check_eq("mrst.m_user", 512'(o_m_user), 512'(0));
    check_eq("mrst.m_data", 512'(o_m_data), 512'(0));
    check_eq("mrst.m_keep", 512'(o_m_keep), 512'(0));
    check_eq("mrst.err_cnt", 512'(o_err_cnt), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_err_cnt = 0;
    clear_all();
    add_sub(8'h62, 64'h9000, 11'd8, 1'b1, 11'd8, 1, 8'hFF);
    exp_user_q.push_back(mk_user(8'h62, 64'h9000, 11'd8, 1'b1, 11'd8));
    exp_dw_q.push_back(11'd8);
    run_traffic(0, 0);
    check_results("post_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
